// File: rtl/rx_buf_alloc_ctrl_pkg.sv
// Shared constants and FSM encoding for the receive buffer allocation controller.
package rx_buf_pkg;

  localparam int POOL_DEPTH = 32;
  localparam int CNT_W      = 3;
  localparam int PTR_W      = 6;
  localparam int BASE_W     = $clog2(POOL_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    GRANT  = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/rx_buf_alloc_ctrl_if.sv
// Request/grant and pool-side signals between receive engines, buffer pool and allocator.
interface rx_buf_alloc_ctrl_if
  import rx_buf_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ*CNT_W-1:0] reqNum;
  logic [NUM_REQ-1:0]       reqAck;
  logic [BASE_W-1:0]        grantBase;
  logic                     bufRegister;
  logic [CNT_W-1:0]         rgstrNum;
  logic [PTR_W-1:0]         rgstrPtr;
  logic [PTR_W-1:0]         lastNum;
  logic                     poolEmpty;
  logic                     slotDone;
  logic                     bufRelease;
  logic                     freshMapping;
  logic                     busy;
  logic                     relOverflow;

  // Engines and pool side.
  modport master (
    output reqValid, reqNum, rgstrPtr, lastNum, poolEmpty, slotDone,
    input  reqAck, grantBase, bufRegister, rgstrNum, bufRelease, freshMapping,
           busy, relOverflow
  );

  // Allocation controller side.
  modport slave (
    input  reqValid, reqNum, rgstrPtr, lastNum, poolEmpty, slotDone,
    output reqAck, grantBase, bufRegister, rgstrNum, bufRelease, freshMapping,
           busy, relOverflow
  );

endinterface

// File: rtl/rx_buf_alloc_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after i_ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  int w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= NUM_REQ) w_c = w_c - NUM_REQ;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = IW'(w_c);
      end
    end
  end

endmodule

// File: rtl/rx_buf_alloc_ctrl.sv
// Round-robin slot allocator (ack 2 cycles after request, one grant per 4 cycles; oversize
// requests hold in CHECK) plus a paced release path (release 1 cycle after slotDone).
module rx_buf_alloc_ctrl
  import rx_buf_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic               clock,
  input logic               reset,
  rx_buf_alloc_ctrl_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_id;
  logic [CNT_W-1:0]   r_num;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [BASE_W-1:0]  r_grant_base;
  logic               r_buf_register;
  logic [CNT_W-1:0]   r_rgstr_num;

  logic [PTR_W-1:0]   r_pend_rel;
  logic               r_buf_release;
  logic               r_fresh_mapping;
  logic               r_rel_overflow;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [PTR_W:0]     w_avail;
  logic               w_fire;
  logic [PTR_W:0]     w_next;
  logic               w_drop;
  logic               w_unused_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (bus.reqValid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_unused_ptr = ^{bus.rgstrPtr[PTR_W-1:BASE_W], w_gnt};

  // Output pulses default low every cycle; only the CHECK->GRANT transition raises them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_id           <= '0;
      r_num          <= '0;
      r_req_ack      <= '0;
      r_grant_base   <= '0;
      r_buf_register <= 1'b0;
      r_rgstr_num    <= '0;
    end else begin
      r_req_ack      <= '0;
      r_buf_register <= 1'b0;
      r_rgstr_num    <= '0;
      r_grant_base   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id    <= w_idx;
            r_num   <= bus.reqNum[int'(w_idx)*CNT_W +: CNT_W];
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (PTR_W'(r_num) <= bus.lastNum) begin
            r_req_ack      <= NUM_REQ'(1) << r_id;
            r_grant_base   <= bus.rgstrPtr[BASE_W-1:0];
            r_buf_register <= (r_num != '0);
            r_rgstr_num    <= r_num;
            r_state        <= GRANT;
          end
        end
        GRANT: begin
          r_rr_ptr <= (r_id == IW'(NUM_REQ-1)) ? '0 : r_id + IW'(1);
          r_state  <= SETTLE;
        end
        SETTLE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count the incoming pulse before deciding, so a lone slotDone releases on the next edge.
  assign w_avail = {1'b0, r_pend_rel} + (PTR_W+1)'(bus.slotDone);
  assign w_fire  = (w_avail != '0) && !bus.poolEmpty;
  assign w_next  = w_avail - (PTR_W+1)'(w_fire);
  assign w_drop  = (w_next > (PTR_W+1)'(POOL_DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_rel      <= '0;
      r_buf_release   <= 1'b0;
      r_fresh_mapping <= 1'b0;
      r_rel_overflow  <= 1'b0;
    end else begin
      r_buf_release   <= w_fire;
      r_fresh_mapping <= r_buf_release;
      if (w_drop) begin
        r_pend_rel     <= PTR_W'(POOL_DEPTH);
        r_rel_overflow <= 1'b1;
      end else begin
        r_pend_rel <= w_next[PTR_W-1:0];
      end
    end
  end

  assign bus.reqAck       = r_req_ack;
  assign bus.grantBase    = r_grant_base;
  assign bus.bufRegister  = r_buf_register;
  assign bus.rgstrNum     = r_rgstr_num;
  assign bus.bufRelease   = r_buf_release;
  assign bus.freshMapping = r_fresh_mapping;
  assign bus.busy         = (r_state != IDLE);
  assign bus.relOverflow  = r_rel_overflow;

endmodule

// File: tb/tb_rx_buf_alloc_ctrl.sv
// Directed bench for rx_buf_alloc_ctrl: grants, round robin, space hold, release pacing, overflow, reset.
module tb_rx_buf_alloc_ctrl;
  import rx_buf_pkg::*;

  localparam int NR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rx_buf_alloc_ctrl_if #(.NUM_REQ(NR)) bus();

  rx_buf_alloc_ctrl #(.NUM_REQ(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.reqValid = '0;
    bus.reqNum   = '0;
    bus.slotDone = 1'b0;
    bus.poolEmpty = 1'b0;
    bus.lastNum  = 6'd32;
    bus.rgstrPtr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.reqAck == '0 && cyc < 12);
  endtask

  initial begin
    int cyc;
    int acks;
    int rel_cnt;
    int fm_cnt;
    logic [7:0] rel_pat;
    logic [7:0] fm_pat;

    // Reset state
    do_reset();
    check("rst_ack",   bus.reqAck, 0);
    check("rst_reg",   bus.bufRegister, 0);
    check("rst_num",   bus.rgstrNum, 0);
    check("rst_base",  bus.grantBase, 0);
    check("rst_rel",   bus.bufRelease, 0);
    check("rst_fresh", bus.freshMapping, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_ovf",   bus.relOverflow, 0);

    // Single request: req0 num=3
    bus.reqNum[2:0] = 3'd3;
    bus.reqValid    = 4'b0001;
    step();
    check("t1_busy_check", bus.busy, 1);
    check("t1_noack_check", bus.reqAck, 0);
    step();
    check("t1_ack",  bus.reqAck, 4'b0001);
    check("t1_reg",  bus.bufRegister, 1);
    check("t1_num",  bus.rgstrNum, 3);
    check("t1_base", bus.grantBase, 0);
    bus.reqValid = '0;
    bus.rgstrPtr = 6'd3;
    step();
    check("t1_ack_pulse", bus.reqAck, 0);
    check("t1_reg_pulse", bus.bufRegister, 0);
    step();
    check("t1_idle", bus.busy, 0);

    // Zero-count request: ack without register strobe
    bus.reqNum[11:9] = 3'd0;
    bus.reqValid     = 4'b1000;
    wait_ack(cyc);
    check("t1b_lat",  cyc, 2);
    check("t1b_ack",  bus.reqAck, 4'b1000);
    check("t1b_reg",  bus.bufRegister, 0);
    check("t1b_base", bus.grantBase, 3);
    bus.reqValid = '0;
    repeat (3) step();

    // Round robin: all four valid, num=1 each
    do_reset();
    bus.reqNum   = 12'b001_001_001_001;
    bus.reqValid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(cyc);
      check($sformatf("rr%0d_spacing", g), cyc, (g == 0) ? 2 : 4);
      check($sformatf("rr%0d_ack", g), bus.reqAck, 4'b0001 << (g % 4));
      check($sformatf("rr%0d_base", g), bus.grantBase, g);
      check($sformatf("rr%0d_num", g), bus.rgstrNum, 1);
      bus.rgstrPtr = 6'(g + 1);
    end
    bus.reqValid = '0;
    repeat (3) step();

    // Insufficient space: req1 num=5 holds, req2 num=1 must not bypass
    do_reset();
    bus.lastNum      = 6'd2;
    bus.reqNum[5:3]  = 3'd5;
    bus.reqNum[8:6]  = 3'd1;
    bus.reqValid     = 4'b0110;
    acks = 0;
    repeat (10) begin
      step();
      if (bus.reqAck != '0) acks++;
    end
    check("t3_no_ack", acks, 0);
    check("t3_busy_hold", bus.busy, 1);
    bus.lastNum = 6'd5;
    step();
    check("t3_ack_req1", bus.reqAck, 4'b0010);
    check("t3_num", bus.rgstrNum, 5);
    bus.reqValid = 4'b0100;
    bus.rgstrPtr = 6'd5;
    wait_ack(cyc);
    check("t3_req2_spacing", cyc, 4);
    check("t3_ack_req2", bus.reqAck, 4'b0100);
    check("t3_req2_base", bus.grantBase, 5);
    bus.reqValid = '0;
    repeat (3) step();

    // Release pacing: 3 back-to-back slotDone
    do_reset();
    rel_pat = '0;
    fm_pat  = '0;
    bus.slotDone = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      rel_pat[k] = bus.bufRelease;
      fm_pat[k]  = bus.freshMapping;
      bus.slotDone = (k < 3);
    end
    check("t4_rel_pattern", rel_pat, 8'b0000_1110);
    check("t4_fresh_pattern", fm_pat, 8'b0001_1100);
    check("t4_no_ovf", bus.relOverflow, 0);

    // Hold while pool empty, overflow on the 33rd slotDone, then drain 32
    do_reset();
    bus.poolEmpty = 1'b1;
    bus.slotDone  = 1'b1;
    rel_cnt = 0;
    for (int k = 1; k <= 33; k++) begin
      step();
      rel_cnt += int'(bus.bufRelease);
      if (k == 32) check("t5_no_ovf_at_32", bus.relOverflow, 0);
      if (k == 33) bus.slotDone = 1'b0;
    end
    check("t5_held_rel", rel_cnt, 0);
    check("t5_ovf", bus.relOverflow, 1);
    bus.poolEmpty = 1'b0;
    rel_cnt = 0;
    fm_cnt  = 0;
    repeat (40) begin
      step();
      rel_cnt += int'(bus.bufRelease);
      fm_cnt  += int'(bus.freshMapping);
    end
    check("t5_drain_rel", rel_cnt, 32);
    check("t5_drain_fresh", fm_cnt, 32);
    check("t5_ovf_sticky", bus.relOverflow, 1);

    // Reset during GRANT, then re-present
    do_reset();
    check("t6_ovf_cleared", bus.relOverflow, 0);
    bus.rgstrPtr    = 6'd9;
    bus.reqNum[8:6] = 3'd2;
    bus.reqValid    = 4'b0100;
    step();
    step();
    check("t6_ack_before", bus.reqAck, 4'b0100);
    check("t6_base_before", bus.grantBase, 9);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_ack",  bus.reqAck, 0);
    check("t6_rst_reg",  bus.bufRegister, 0);
    check("t6_rst_num",  bus.rgstrNum, 0);
    check("t6_rst_base", bus.grantBase, 0);
    check("t6_rst_busy", bus.busy, 0);
    #1 reset = 1'b0;
    step();
    step();
    check("t6_regrant_ack", bus.reqAck, 4'b0100);
    check("t6_regrant_reg", bus.bufRegister, 1);
    check("t6_regrant_num", bus.rgstrNum, 2);
    bus.reqValid = '0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
